responder_sequencer: RTL and testbench

- Sits directly downstream of the tag stage in the content-addressable parallel processor.
- Captures the tag vector after a search and walks through every responding word in ascending index order, one word per accepted handshake.
- Each presented responder carries its word index and a one-hot select, used by the cells stage for read-out or multiwrite.
- Provides the some/none summary and a responder count for the controller.

---
 rtl/cam_pkg.sv | 18 +
 rtl/lowest_set_encoder.sv | 24 ++
 rtl/responder_sequencer.sv | 84 ++++++++
 tb/tb_responder_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared constants and types for the CAM responder path.
// Word count, index/count widths, walk FSM states.
package cam_pkg;

  localparam int N_WORDS = 100;
  localparam int IDX_W   = 7;
  localparam int CNT_W   = 7;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FINISH
  } state_t;

  typedef logic [N_WORDS-1:0] tag_vec_t;
  typedef logic [IDX_W-1:0]   word_idx_t;

endpackage

// File: rtl/lowest_set_encoder.sv
// Lowest-set-bit encoder over a tag vector.
// In: vec. Out: index, onehot, any.
module lowest_set_encoder
  import cam_pkg::*;
(
  input  tag_vec_t  vec,
  output word_idx_t index,
  output tag_vec_t  onehot,
  output logic      any
);

  always_comb begin
    index = '0;
    // Scan high to low so the lowest set bit wins.
    for (int i = N_WORDS - 1; i >= 0; i--) begin
      if (vec[i]) index = word_idx_t'(i);
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = vec & (~vec + tag_vec_t'(1));
  assign any    = |vec;

endmodule

// File: rtl/responder_sequencer.sv
// Walks captured responders lowest-index first, one per handshake.
// In: CLK, RST, tags_in, start, out_ready. Out: out_*, some, none, busy, done, count.
module responder_sequencer
  import cam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_WORDS-1:0] tags_in,
  input  logic             start,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic [N_WORDS-1:0] out_onehot,
  output logic             some,
  output logic             none,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  state_t    state, state_nx;
  tag_vec_t  pending;
  word_idx_t low_idx;
  tag_vec_t  low_oh;
  logic      any;
  logic      hs;
  logic      last;

  lowest_set_encoder u_enc (
    .vec    (pending),
    .index  (low_idx),
    .onehot (low_oh),
    .any    (any)
  );

  assign hs   = out_valid & out_ready;
  // Handshake on the final pending bit ends the walk.
  assign last = ~|(pending & ~low_oh);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (|tags_in) ? SCAN : FINISH;
      end
      SCAN: begin
        if (hs && last) state_nx = FINISH;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    out_valid  = (state == SCAN) && any;
    out_index  = low_idx;
    out_onehot = low_oh;
    busy       = (state != IDLE);
    done       = (state == FINISH);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending <= '0;
      count   <= '0;
      some    <= 1'b0;
      none    <= 1'b0;
    end else if (state == IDLE && start) begin
      pending <= tags_in;
      count   <= '0;
      some    <= |tags_in;
      none    <= ~|tags_in;
    end else if (state == SCAN && hs) begin
      pending <= pending & ~low_oh;
      count   <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_responder_sequencer.sv
// Directed self-checking bench for responder_sequencer.
// Drives start/tags/out_ready; checks walk order, counts and pulses.
module tb_responder_sequencer;
  import cam_pkg::*;

  logic             CLK = 1'b0;
  logic             RST;
  logic [N_WORDS-1:0] tags_in;
  logic             start;
  logic             out_ready;
  logic             out_valid;
  logic [IDX_W-1:0] out_index;
  logic [N_WORDS-1:0] out_onehot;
  logic             some;
  logic             none;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;

  responder_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .tags_in    (tags_in),
    .start      (start),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_index  (out_index),
    .out_onehot (out_onehot),
    .some       (some),
    .none       (none),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic tag_vec_t oh(input int i);
    tag_vec_t v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    RST = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    tags_in = '0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_some", some, 0);
    chk("rst_none", none, 0);
    chk("rst_index", out_index, 0);
    chk("rst_onehot", out_onehot, 0);
    tick();
    RST = 1'b0;
    tick();

    // Empty capture
    tags_in = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_done", done, 1);
    chk("empty_none", none, 1);
    chk("empty_some", some, 0);
    chk("empty_valid", out_valid, 0);
    chk("empty_busy", busy, 1);
    chk("empty_count", count, 0);
    tick();
    chk("empty_done_off", done, 0);
    chk("empty_idle", busy, 0);
    chk("empty_none_hold", none, 1);

    // Sparse walk; out_ready high with start
    tags_in = oh(3) | oh(17) | oh(99);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tags_in = oh(0) | oh(1);
    chk("sp_count0", count, 0);
    chk("sp_some", some, 1);
    chk("sp_none", none, 0);
    chk("sp_v0", out_valid, 1);
    chk("sp_i0", out_index, 3);
    chk("sp_o0", out_onehot, oh(3));
    tick();
    chk("sp_i1", out_index, 17);
    chk("sp_o1", out_onehot, oh(17));
    tick();
    chk("sp_i2", out_index, 99);
    chk("sp_o2", out_onehot, oh(99));
    chk("sp_v2", out_valid, 1);
    tick();
    chk("sp_done", done, 1);
    chk("sp_valid_end", out_valid, 0);
    chk("sp_count", count, 3);
    tick();
    chk("sp_done_off", done, 0);
    tick();
    chk("sp_ready_idle", count, 3);
    chk("sp_some_hold", some, 1);

    // Backpressure
    out_ready = 1'b0;
    tags_in = oh(5) | oh(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_hold_v", out_valid, 1);
      chk("bp_hold_i", out_index, 5);
      if (c < 3) tick();
    end
    chk("bp_hold_cnt", count, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_i6", out_index, 6);
    chk("bp_cnt1", count, 1);
    tick();
    chk("bp_done", done, 1);
    chk("bp_count", count, 2);
    tick();

    // Start while busy is ignored
    tags_in = oh(0) | oh(50);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ig_i0", out_index, 0);
    tags_in = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ig_i50", out_index, 50);
    chk("ig_cnt1", count, 1);
    tick();
    chk("ig_done", done, 1);
    chk("ig_count", count, 2);
    chk("ig_valid", out_valid, 0);
    tick();
    chk("ig_idle", busy, 0);

    // Full vector
    tags_in = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N_WORDS; i++) begin
      chk("full_v", out_valid, 1);
      chk("full_i", out_index, i);
      chk("full_o", out_onehot, oh(i));
      chk("full_nodone", done, 0);
      tick();
    end
    chk("full_done", done, 1);
    chk("full_count", count, 100);
    chk("full_valid_end", out_valid, 0);
    tick();
    chk("full_done_off", done, 0);

    // Reset mid-walk
    out_ready = 1'b0;
    tags_in = oh(1) | oh(2) | oh(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rm_i1", out_index, 1);
    out_ready = 1'b1;
    tick();
    chk("rm_i2", out_index, 2);
    chk("rm_cnt1", count, 1);
    #1;
    RST = 1'b1;
    #1;
    chk("rm_valid", out_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_count", count, 0);
    chk("rm_done", done, 0);
    tick();
    chk("rm_done_after", done, 0);
    RST = 1'b0;
    tick();
    chk("rm_done_idle", done, 0);
    tags_in = oh(7);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rm_restart_i", out_index, 7);
    chk("rm_restart_v", out_valid, 1);
    tick();
    chk("rm_restart_done", done, 1);
    chk("rm_restart_cnt", count, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
